// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared types and parameter defaults for the S/R drive encoder
//
// Contents:
//   sr_state_t      encoder FSM states (idle, pulse, guard gap)
//   SR_*_DEF        default pulse width, gap width and counter width
package sr_pkg;

  typedef enum logic [1:0] {
    SR_IDLE  = 2'd0,
    SR_PULSE = 2'd1,
    SR_GAP   = 2'd2
  } sr_state_t;

  localparam int SR_PULSE_W_DEF = 4;
  localparam int SR_GAP_W_DEF   = 2;
  localparam int SR_CNT_W_DEF   = 8;

endpackage

// File: rtl/sr_tick_counter.sv
// rtl/sr_tick_counter.sv - loadable down-counter shared by pulse and gap timing
//
// Ports:
//   clk_i       clock, rising edge
//   rst_n_i     asynchronous active-low reset (counter clears to 0)
//   load_i      load load_val_i on the next edge (has priority over dec_i)
//   load_val_i  value to load
//   dec_i       decrement on the next edge; saturates at 0
//   zero_o      counter currently equals 0
module sr_tick_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_drive_encoder.sv
// rtl/sr_drive_encoder.sv - timed, mutually exclusive S/R pulse generator with state model
//
// Optional feature macro: SR_FEEDBACK_CHECK_EN (compare q_fb_i with the target
// at the end of every pulse and raise a sticky err_o on mismatch).
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   req_valid_i  request present
//   req_ready_o  encoder idle and able to accept (state decode only)
//   req_level_i  requested Q level (1 = set, 0 = reset)
//   req_force_i  pulse even if the level already matches the model
//   s_o, r_o     registered set / reset drives
//   q_model_o    registered model of the flip-flop state
//   busy_o       pulse or guard gap in progress
//   q_fb_i       flip-flop Q feedback (check feature only)
//   err_clr_i    synchronous clear of err_o (check feature only)
//   err_o        sticky feedback mismatch flag
module sr_drive_encoder
  import sr_pkg::*;
#(
  parameter int PULSE_W = SR_PULSE_W_DEF,
  parameter int GAP_W   = SR_GAP_W_DEF,
  parameter int CNT_W   = SR_CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic req_valid_i,
  output logic req_ready_o,
  input  logic req_level_i,
  input  logic req_force_i,
  output logic s_o,
  output logic r_o,
  output logic q_model_o,
  output logic busy_o,
  input  logic q_fb_i,
  input  logic err_clr_i,
  output logic err_o
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_W > 0) ? CNT_W'(GAP_W - 1) : '0;

  sr_state_t        state_q, state_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             q_model_q, q_model_d;
  logic             target_q, target_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             chk_fire;

  sr_tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    r_d          = r_q;
    q_model_d    = q_model_q;
    target_d     = target_q;
    cnt_load     = 1'b0;
    cnt_load_val = PULSE_LOAD;
    cnt_dec      = 1'b0;

    case (state_q)
      SR_IDLE: begin
        // A matching, unforced request is swallowed here without leaving IDLE.
        if (req_valid_i && ((req_level_i != q_model_q) || req_force_i)) begin
          state_d      = SR_PULSE;
          target_d     = req_level_i;
          s_d          = req_level_i;
          r_d          = ~req_level_i;
          cnt_load     = 1'b1;
          cnt_load_val = PULSE_LOAD;
        end
      end
      SR_PULSE: begin
        if (cnt_zero) begin
          s_d       = 1'b0;
          r_d       = 1'b0;
          q_model_d = target_q;
          if (GAP_W > 0) begin
            state_d      = SR_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LOAD;
          end else begin
            state_d = SR_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      SR_GAP: begin
        if (cnt_zero) begin
          state_d = SR_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d = SR_IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= SR_IDLE;
      s_q       <= 1'b0;
      r_q       <= 1'b0;
      q_model_q <= 1'b0;
      target_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      r_q       <= r_d;
      q_model_q <= q_model_d;
      target_q  <= target_d;
    end
  end

  // The last pulse cycle: the flip-flop has been driven for PULSE_W-1 edges.
  assign chk_fire = (state_q == SR_PULSE) && cnt_zero;

`ifdef SR_FEEDBACK_CHECK_EN
  logic err_q, err_d;

  // A fresh mismatch wins over a simultaneous clear.
  always_comb begin
    err_d = err_q & ~err_clr_i;
    if (chk_fire && (q_fb_i != target_q)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_fb;
  assign unused_fb = ^{q_fb_i, err_clr_i, chk_fire};
  assign err_o     = 1'b0;
`endif

  assign s_o         = s_q;
  assign r_o         = r_q;
  assign q_model_o   = q_model_q;
  assign req_ready_o = (state_q == SR_IDLE);
  assign busy_o      = (state_q != SR_IDLE);

endmodule

// File: tb/tb_sr_drive_encoder.sv
// tb/tb_sr_drive_encoder.sv - scoreboard bench for sr_drive_encoder (directed + random)
module tb_sr_drive_encoder;

  localparam int PW = 4;
  localparam int GW = 2;
`ifdef SR_FEEDBACK_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_level = 1'b0;
  logic req_force = 1'b0;
  logic err_clr = 1'b0;
  logic req_ready, s, r, q_model, busy, err, q_fb;

  logic v0 = 1'b0;
  logic l0 = 1'b0;
  logic ready0, s0, r0, qm0, busy0, err0;

  always #5 clk = ~clk;

  sr_drive_encoder #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(8)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_level_i(req_level), .req_force_i(req_force), .s_o(s), .r_o(r),
    .q_model_o(q_model), .busy_o(busy), .q_fb_i(q_fb), .err_clr_i(err_clr), .err_o(err)
  );

  sr_drive_encoder #(.PULSE_W(PW), .GAP_W(0), .CNT_W(8)) u_dut0 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(v0), .req_ready_o(ready0),
    .req_level_i(l0), .req_force_i(1'b0), .s_o(s0), .r_o(r0),
    .q_model_o(qm0), .busy_o(busy0), .q_fb_i(s0), .err_clr_i(1'b0), .err_o(err0)
  );

  // Behavioural flip-flop driven by the DUT, used as feedback.
  logic ff_q;
  logic fb_break = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 1'b0;
    else if (s) ff_q <= 1'b1;
    else if (r) ff_q <= 1'b0;
  end
  assign q_fb = fb_break ? 1'b0 : ff_q;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: flip-flop level and queue of expected pulse targets.
  bit model_q = 1'b0;
  bit exp_q[$];
  int n_pulse_exp = 0;
  int n_pulse_seen = 0;

  // Present a request at a negedge; returns at the negedge after acceptance.
  task automatic issue(input bit lvl, input bit frc);
    int waitc;
    waitc = 0;
    req_valid = 1'b1;
    req_level = lvl;
    req_force = frc;
    while (!req_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (!((lvl == model_q) && !frc)) begin
        exp_q.push_back(lvl);
        model_q = lvl;
        n_pulse_exp++;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: consumes expected pulses as the DUT produces them.
  bit mon_en = 1'b0;
  bit in_pulse = 1'b0;
  bit cur_lvl = 1'b0;
  int plen = 0;
  int low_cnt = 0;

  always @(negedge clk) begin
    if (!mon_en) begin
      in_pulse = 1'b0;
      low_cnt  = 0;
    end else begin
      if (s || r) begin
        chk("s_r_exclusive", int'(s && r), 0);
        if (!in_pulse) begin
          in_pulse = 1'b1;
          plen = 1;
          n_pulse_seen++;
          if (exp_q.size() == 0) begin
            chk("pulse_expected", 0, 1);
            cur_lvl = s;
          end else begin
            cur_lvl = exp_q.pop_front();
            chk("pulse_line_s", int'(s), int'(cur_lvl));
            chk("pulse_line_r", int'(r), int'(!cur_lvl));
          end
        end else begin
          plen++;
        end
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        chk("pulse_len", plen, PW);
        chk("q_model_after_pulse", int'(q_model), int'(cur_lvl));
      end
      if (!req_ready) begin
        low_cnt++;
      end else if (low_cnt != 0) begin
        chk("ready_low_len", low_cnt, PW + GW);
        low_cnt = 0;
      end
    end
  end

  initial begin
    int n;
    int hi;
    bit lvl, frc;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_s", int'(s), 0);
    chk("rst_r", int'(r), 0);
    chk("rst_q_model", int'(q_model), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(req_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Set from reset
    issue(1'b1, 1'b0);
    chk("t1_s_first_cycle", int'(s), 1);
    chk("t1_busy", int'(busy), 1);
    idle(PW + GW + 2);

    // No-op then immediate reset request
    issue(1'b1, 1'b0);
    chk("t2_noop_ready", int'(req_ready), 1);
    chk("t2_noop_no_pulse", int'(s || r), 0);
    issue(1'b0, 1'b0);
    chk("t2_r_first_cycle", int'(r), 1);
    idle(PW + GW + 2);
    chk("t2_q_model", int'(q_model), 0);

    // Forced set while already set
    issue(1'b1, 1'b0);
    idle(PW + GW + 2);
    issue(1'b1, 1'b1);
    chk("t3_forced_s", int'(s), 1);
    idle(PW + GW + 2);
    chk("t3_q_model", int'(q_model), 1);

    // Feedback mismatch on a forced set pulse
    fb_break = 1'b1;
    issue(1'b1, 1'b1);
    idle(PW);
    chk("t4_err_after_pulse", int'(err), EXP_ERR);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("t4_err_cleared", int'(err), 0);
    fb_break = 1'b0;
    idle(PW);

    // Asynchronous reset during the second pulse cycle
    mon_en = 1'b0;
    req_valid = 1'b1;
    req_level = 1'b0;
    req_force = 1'b0;
    chk("t5_ready_before", int'(req_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t5_r_pulsing", int'(r), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_s", int'(s), 0);
    chk("t5_rst_r", int'(r), 0);
    chk("t5_rst_q_model", int'(q_model), 0);
    chk("t5_rst_ready", int'(req_ready), 1);
    chk("t5_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (s || r) hi++;
    end
    chk("t5_no_pulse_after_reset", hi, 0);
    model_q = 1'b0;
    exp_q.delete();

    // GAP_W = 0 instance: ready returns right after the last pulse cycle
    v0 = 1'b1;
    l0 = 1'b1;
    chk("t6_ready0_before", int'(ready0), 1);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
    n = 0;
    hi = 0;
    while (!ready0 && n < 50) begin
      if (s0) hi++;
      n++;
      @(negedge clk);
    end
    chk("t6_gap0_ready_low", n, PW);
    chk("t6_gap0_s_cycles", hi, PW);
    chk("t6_gap0_q_model", int'(qm0), 1);
    chk("t6_gap0_s_low", int'(s0), 0);

    // Random request stream
    mon_en = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      lvl = 1'($urandom_range(0, 1));
      frc = ($urandom_range(0, 3) == 0);
      issue(lvl, frc);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
    end
    idle(PW + GW + 3);
    chk("rand_pulse_count", n_pulse_seen, n_pulse_exp);
    chk("rand_queue_drained", exp_q.size(), 0);
    chk("rand_q_model_final", int'(q_model), int'(model_q));
    chk("rand_err_clean", int'(err), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sr_drive_encoder.md
# sr_drive_encoder

Clocked command encoder that drives the S/R inputs of the `sr_flipflop` storage element. It accepts target-level requests over a valid/ready handshake and emits one timed, mutually exclusive S or R pulse per request, followed by a guard gap. It keeps a model of the flip-flop state, so redundant requests are absorbed without pulsing. Optionally, it checks the flip-flop's Q against the model after each pulse.

## Interface
- PULSE_W, 4, cycles S or R is held high per pulse; must satisfy 1 ≤ PULSE_W < 2**CNT_W
- GAP_W, 2, idle cycles enforced after each pulse; must satisfy 0 ≤ GAP_W < 2**CNT_W
- CNT_W, 8, width of the internal cycle counter
- CLK  input  1  clock; all state updates on the rising edge
- RST_N  input  1  asynchronous, active-low reset
- REQ_VALID  input  1  request present
- REQ_READY  output  1  block can accept a request; high exactly when the FSM is in IDLE
- REQ_LEVEL  input  1  requested Q level (1 = set, 0 = reset)
- REQ_FORCE  input  1  pulse even when REQ_LEVEL equals Q_MODEL
- S  output  1  set drive to the flip-flop, registered
- R  output  1  reset drive to the flip-flop, registered
- Q_MODEL  output  1  modelled flip-flop state, registered
- BUSY  output  1  high in PULSE or GAP
- Q_FB  input  1  Q fed back from the flip-flop (used only with the check feature)
- ERR_CLR  input  1  synchronous clear of ERR
- ERR  output  1  sticky feedback-mismatch flag

## Operation
- **Reset (RST_N low):** takes effect immediately, including mid-pulse or mid-gap.
  - State goes to IDLE.
  - S=0, R=0, Q_MODEL=0, ERR=0, BUSY=0, REQ_READY=1 once the FSM is in IDLE.
- **Accept:** a request is accepted on the rising edge where REQ_VALID && REQ_READY.
- **FSM states:** IDLE, PULSE, GAP.
- **IDLE, accepted request with REQ_LEVEL == Q_MODEL and REQ_FORCE == 0:**
  - The request is a no-op and is consumed.
  - The FSM stays in IDLE and REQ_READY stays high, so back-to-back accepts on consecutive cycles are legal.
- **IDLE, any other accepted request:**
  - The target is latched and the FSM goes to PULSE.
  - The counter loads PULSE_W−1.
  - S = REQ_LEVEL and R = ~REQ_LEVEL are registered on the same edge.
- **PULSE:**
  - The counter decrements each cycle.
  - At count 0, the next edge clears S and R and sets Q_MODEL to the target.
  - If GAP_W > 0, the FSM goes to GAP with the counter loaded to GAP_W−1; otherwise it goes directly to IDLE.
- **GAP:**
  - The counter decrements each cycle.
  - At count 0, the FSM goes to IDLE.
- **Invariant:** S and R are never high in the same cycle.
- **Handshake rules:**
  - REQ_LEVEL and REQ_FORCE are sampled only at accept.
  - Requests presented while REQ_READY is low are ignored.
  - The requester must hold a request until it is accepted.
- **ERR:**
  - ERR_CLR and a new mismatch in the same cycle leave ERR set.
  - Without the check feature, ERR_CLR has no effect.

## Timing
- Accept at edge k:
  - S or R is high for cycles k+1 … k+PULSE_W.
  - Q_MODEL changes after edge k+PULSE_W.
  - REQ_READY is low from edge k until edge k+PULSE_W+GAP_W, and high after it.
- Occupancy per pulsing request is PULSE_W+GAP_W cycles. A no-op costs 1 cycle.
- Peak throughput is one pulse per PULSE_W+GAP_W cycles.
- There is no combinational path from any input to S, R, Q_MODEL or ERR.
- REQ_READY is decoded from state only and does not depend on REQ_VALID.

## Configuration
- Macro: SR_FEEDBACK_CHECK_EN.
- **Defined:**
  - Q_FB is sampled on the edge that ends the last PULSE cycle.
  - If Q_FB ≠ target, ERR is set and stays high until RST_N or ERR_CLR.
  - ERR_CLR clears ERR on the next edge.
- **Undefined:**
  - Q_FB and ERR_CLR are present but ignored.
  - ERR is tied to 0.
  - No check logic is synthesized.

## Structure
- **Package `sr_pkg`:**
  - typedef enum `sr_state_t` {SR_IDLE, SR_PULSE, SR_GAP}.
  - localparam defaults for PULSE_W, GAP_W and CNT_W.
- **Sub-module `sr_tick_counter`:**
  - Loadable CNT_W-bit down-counter with `load`, `load_val`, `dec` and a `zero` flag.
  - The same instance is reused for both PULSE and GAP timing.

## Test plan
- Reset, then request LEVEL=1, FORCE=0 accepted at edge k (defaults) → S high for cycles k+1..k+4, R=0, Q_MODEL=1 after edge k+4, REQ_READY high after edge k+6.
- With Q_MODEL=1, request LEVEL=1, FORCE=0 → no pulse, REQ_READY stays high; a second request LEVEL=0 on the next cycle is accepted and R pulses for 4 cycles.
- With Q_MODEL=1, request LEVEL=1, FORCE=1 → S pulses for 4 cycles, Q_MODEL stays 1.
- Assert RST_N low during the 2nd PULSE cycle → S=0, Q_MODEL=0 and REQ_READY=1 immediately, with no further pulse after release; GAP_W=0 variant → REQ_READY high directly after the last pulse cycle.
- With SR_FEEDBACK_CHECK_EN, Q_FB held 0 during a set pulse → ERR=1 after edge k+4; ERR_CLR for 1 cycle → ERR=0; without the macro the same stimulus leaves ERR=0.
- Random request stream over 10k cycles → assertion that S&&R never holds, and that S/R pulse count equals the count of non-no-op accepts.
